// File: rtl/game_pkg.sv
// game_pkg: FSM states and seven-segment patterns shared by the game-period blocks
package game_pkg;

    typedef enum logic [1:0] {IDLE, ANSWER, CHECK, RESULT} state_t;

    // Bit order {dp, a, b, c, d, e, f, g}
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B
    };
    localparam logic [7:0] SEG_DASH  = 8'b0000_0001;
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_Y     = 8'h3B;
    localparam logic [7:0] SEG_N     = 8'h15;

    // Pattern of the least significant decimal digit of v
    function automatic logic [7:0] seg_digit(input logic [7:0] v);
        return SEG_DIGIT[4'(v % 8'd10)];
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect one raw button into a 1-cycle press
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES cycles
    always_comb begin
        sync_d   = {sync_q[0], btn};
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1))
                stable_d = sync_q[1];
            else
                cnt_d = cnt_q + 1'b1;
        end
        press_d = stable_d & ~stable_q;
    end

    // Conditioner state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/answer_period.sv
// answer_period: answer phase of the game - guess entry, timeout, verdict, score and display
module answer_period
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC   = 100_000_000,
    parameter int ANSWER_SECS     = 10,
    parameter int RESULT_SECS     = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       Clk100M,
    input  logic       Rst_n,
    input  logic       answerSig,
    input  logic [7:0] numSpecial,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnSubmit,
    output logic       busy,
    output logic       resultValid,
    output logic       resultCorrect,
    output logic [7:0] score,
    output logic [7:0] answerSeg0,
    output logic [7:0] answerSeg1,
    output logic [7:0] answerSeg2,
    output logic [7:0] answerSeg3
);
    localparam int DW = $clog2(TICKS_PER_SEC + 1);

    state_t          state_q, state_d;
    logic [7:0]      guess_q, guess_d;
    logic [7:0]      target_q, target_d;
    logic [7:0]      secs_q, secs_d;
    logic [7:0]      score_q, score_d;
    logic [DW-1:0]   div_q, div_d;
    logic            busy_q, busy_d;
    logic            rv_q, rv_d;
    logic            rc_q, rc_d;
    logic [3:0][7:0] seg_q, seg_d;
    logic            up_p, down_p, submit_p, tick, match;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(Clk100M), .rst_n(Rst_n), .btn(btnUp), .press(up_p)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(Clk100M), .rst_n(Rst_n), .btn(btnDown), .press(down_p)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_submit (
        .clk(Clk100M), .rst_n(Rst_n), .btn(btnSubmit), .press(submit_p)
    );

    assign tick  = div_q == DW'(TICKS_PER_SEC - 1);
    assign match = guess_q == target_q;

    // Phase sequencing, guess editing, countdown and scoring
    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        target_d = target_q;
        secs_d   = secs_q;
        score_d  = score_q;
        busy_d   = busy_q;
        rv_d     = 1'b0;
        rc_d     = rc_q;
        div_d    = tick ? '0 : div_q + 1'b1;
        case (state_q)
            IDLE: if (answerSig) begin
                target_d = numSpecial;
                guess_d  = 8'd0;
                secs_d   = 8'(ANSWER_SECS);
                rc_d     = 1'b0;
                busy_d   = 1'b1;
                div_d    = '0;
                state_d  = ANSWER;
            end
            ANSWER: begin
                if (!submit_p && up_p && !down_p && guess_q != 8'hFF)
                    guess_d = guess_q + 8'd1;
                if (!submit_p && down_p && !up_p && guess_q != 8'h00)
                    guess_d = guess_q - 8'd1;
                if (tick)
                    secs_d = secs_q - 8'd1;
                if (submit_p || (tick && secs_q == 8'd1))
                    state_d = CHECK;
            end
            CHECK: begin
                rc_d    = match;
                rv_d    = 1'b1;
                score_d = (match && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                secs_d  = 8'(RESULT_SECS);
                div_d   = '0;
                state_d = RESULT;
            end
            RESULT: if (tick) begin
                secs_d = secs_q - 8'd1;
                if (secs_q == 8'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit patterns: countdown+guess while answering, verdict+guess in result, dashes when idle
    always_comb begin
        seg_d = (state_q == IDLE)   ? {4{SEG_DASH}} :
                (state_q == RESULT) ? {rc_q ? SEG_Y : SEG_N, seg_digit(guess_q / 8'd100),
                                       seg_digit(guess_q / 8'd10), seg_digit(guess_q)} :
                                      {seg_digit(secs_q / 8'd10), seg_digit(secs_q),
                                       guess_q >= 8'd100 ? SEG_DASH : seg_digit(guess_q / 8'd10),
                                       seg_digit(guess_q)};
    end

    // All state and outputs registered
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            target_q <= '0;
            secs_q   <= '0;
            score_q  <= '0;
            div_q    <= '0;
            busy_q   <= 1'b0;
            rv_q     <= 1'b0;
            rc_q     <= 1'b0;
            seg_q    <= {4{SEG_DASH}};
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            target_q <= target_d;
            secs_q   <= secs_d;
            score_q  <= score_d;
            div_q    <= div_d;
            busy_q   <= busy_d;
            rv_q     <= rv_d;
            rc_q     <= rc_d;
            seg_q    <= seg_d;
        end
    end

    assign busy          = busy_q;
    assign resultValid   = rv_q;
    assign resultCorrect = rc_q;
    assign score         = score_q;
    assign answerSeg0    = seg_q[0];
    assign answerSeg1    = seg_q[1];
    assign answerSeg2    = seg_q[2];
    assign answerSeg3    = seg_q[3];

endmodule

// File: tb/tb_answer_period.sv
// tb_answer_period: directed and randomized checks of answer_period against a behavioural model
module tb_answer_period;
    localparam int TPS = 40;
    localparam int AS  = 99;
    localparam int RS  = 2;
    localparam int DB  = 4;

    localparam logic [7:0] DIG [10] = '{
        8'h7E, 8'h30, 8'h6D, 8'h79, 8'h33, 8'h5B, 8'h5F, 8'h70, 8'h7F, 8'h7B
    };
    localparam logic [7:0] DASH = 8'h01;
    localparam logic [7:0] SY   = 8'h3B;
    localparam logic [7:0] SN   = 8'h15;

    logic       Clk100M = 1'b0;
    logic       Rst_n = 1'b1;
    logic       answerSig = 1'b0;
    logic [7:0] numSpecial = 8'd0;
    logic       btnUp = 1'b0, btnDown = 1'b0, btnSubmit = 1'b0;
    logic       busy, resultValid, resultCorrect;
    logic [7:0] score, answerSeg0, answerSeg1, answerSeg2, answerSeg3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int m_guess = 0;
    int m_target = 0;
    int m_score = 0;

    answer_period #(
        .TICKS_PER_SEC(TPS), .ANSWER_SECS(AS), .RESULT_SECS(RS), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .answerSig(answerSig), .numSpecial(numSpecial),
        .btnUp(btnUp), .btnDown(btnDown), .btnSubmit(btnSubmit),
        .busy(busy), .resultValid(resultValid), .resultCorrect(resultCorrect), .score(score),
        .answerSeg0(answerSeg0), .answerSeg1(answerSeg1),
        .answerSeg2(answerSeg2), .answerSeg3(answerSeg3)
    );

    always #5 Clk100M = ~Clk100M;
    always @(posedge Clk100M) cyc <= cyc + 1;

    function automatic logic [7:0] d7(input int v);
        return DIG[v % 10];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tickn(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    task automatic chk_guess(input string tag);
        chk({tag, "_seg1"}, answerSeg1, m_guess >= 100 ? DASH : d7(m_guess / 10));
        chk({tag, "_seg0"}, answerSeg0, d7(m_guess));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rv"}, resultValid, 0);
        chk({tag, "_rc"}, resultCorrect, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_segs"}, {answerSeg3, answerSeg2, answerSeg1, answerSeg0}, {4{DASH}});
    endtask

    task automatic press(input logic u, input logic d);
        btnUp = u;
        btnDown = d;
        tickn(5);
        btnUp = 1'b0;
        btnDown = 1'b0;
        tickn(7);
        if (u && !d && m_guess < 255) m_guess++;
        else if (d && !u && m_guess > 0) m_guess--;
    endtask

    task automatic bounce();
        repeat (4) begin
            btnUp = 1'b1;
            tickn($urandom_range(1, DB - 1));
            btnUp = 1'b0;
            tickn($urandom_range(1, DB - 1));
        end
        tickn(8);
    endtask

    task automatic start(input logic [7:0] t);
        answerSig = 1'b1;
        numSpecial = t;
        tickn(1);
        answerSig = 1'b0;
        numSpecial = 8'($urandom);
        chk("busy_rise", busy, 1);
        start_cyc = cyc;
        m_guess = 0;
        m_target = t;
        tickn(1);
        chk("secs_tens", answerSeg3, d7(AS / 10));
        chk("secs_ones", answerSeg2, d7(AS));
        chk_guess("start");
    endtask

    task automatic finish_phase(input logic sub, input logic extra_up, input logic stay);
        int  n;
        bit  seen;
        bit  exp_ok;
        btnSubmit = sub;
        btnUp = sub & extra_up;
        n = 0;
        seen = 0;
        while (!seen && n < AS * TPS + 100) begin
            tickn(1);
            n++;
            seen = resultValid;
        end
        chk("rv_seen", seen, 1);
        if (!sub) chk("timeout_len", cyc - start_cyc, AS * TPS + 1);
        exp_ok = m_guess == m_target;
        if (exp_ok && m_score < 255) m_score++;
        chk("rc", resultCorrect, exp_ok);
        chk("score", score, m_score);
        btnSubmit = 1'b0;
        btnUp = 1'b0;
        if (stay) return;
        tickn(1);
        chk("rv_pulse", resultValid, 0);
        chk("res_seg3", answerSeg3, exp_ok ? SY : SN);
        chk("res_seg2", answerSeg2, d7(m_guess / 100));
        chk("res_seg1", answerSeg1, d7(m_guess / 10));
        chk("res_seg0", answerSeg0, d7(m_guess));
        n = 1;
        while (busy && n < RS * TPS + 10) begin
            tickn(1);
            n++;
        end
        chk("busy_fall", n, RS * TPS);
        tickn(1);
        chk("idle_segs", {answerSeg3, answerSeg2, answerSeg1, answerSeg0}, {4{DASH}});
        chk("rc_held", resultCorrect, exp_ok);
    endtask

    initial begin
        #1 Rst_n = 1'b0;
        #1 chk_reset("por");
        tickn(3);
        Rst_n = 1'b1;
        tickn(2);

        start(8'd5);
        repeat (5) begin
            press(1'b1, 1'b0);
            chk_guess("up5");
        end
        finish_phase(1'b1, 1'b0, 1'b0);

        start(8'd2);
        press(1'b0, 1'b1);
        chk_guess("down_at0");
        press(1'b1, 1'b0);
        chk_guess("up_after");
        finish_phase(1'b0, 1'b0, 1'b0);

        start(8'd7);
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        chk_guess("up_down");
        repeat (3) begin
            bounce();
            chk_guess("bounce");
        end
        finish_phase(1'b1, 1'b1, 1'b0);

        start(8'd255);
        repeat (256) begin
            press(1'b1, 1'b0);
            chk_guess("sat");
        end
        finish_phase(1'b1, 1'b0, 1'b0);

        start(8'd3);
        answerSig = 1'b1;
        numSpecial = 8'd9;
        tickn(1);
        answerSig = 1'b0;
        chk("busy_relatch", busy, 1);
        repeat (3) press(1'b1, 1'b0);
        chk_guess("relatch");
        finish_phase(1'b1, 1'b0, 1'b0);

        start(8'd1);
        finish_phase(1'b1, 1'b0, 1'b1);
        chk("score_pre_rst", score, 3);
        tickn(3);
        Rst_n = 1'b0;
        #1 chk_reset("mid_rst");
        m_score = 0;
        tickn(2);
        Rst_n = 1'b1;
        tickn(2);

        repeat (4) begin
            start(8'($urandom_range(0, 6)));
            for (int i = 0; i < int'($urandom_range(4, 10)); i++) begin
                case ($urandom_range(0, 3))
                    0: press(1'b1, 1'b0);
                    1: press(1'b0, 1'b1);
                    2: press(1'b1, 1'b1);
                    default: bounce();
                endcase
                chk_guess("rnd");
            end
            finish_phase(1'b1, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
